// File: rtl/centroid_calc.sv
// rtl/centroid_calc.sv - foreground centroid of a video frame via serial restoring division
module centroid_calc #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        mask,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic        centroid_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state, state_next;
  logic        vsync_q, de_q, vsync_rise;
  logic [10:0] x_cnt, y_cnt;
  logic [31:0] sum_x, sum_y;
  logic [21:0] cnt;
  logic [31:0] qx, qy, qx_next, qy_next;
  logic [21:0] rx, ry, rx_next, ry_next, divisor;
  logic [22:0] trial_x, trial_y, diff_x, diff_y;
  logic        ge_x, ge_y;
  logic [4:0]  iter;
  logic        load_out;
  logic        unused_ok;

  // hsync and the frame-size parameters do not affect the datapath
  assign unused_ok = &{1'b0, hsync, diff_x[22], diff_y[22], IMG_W[0], IMG_H[0]};

  assign vsync_rise = vsync & ~vsync_q;
  assign busy       = (state != IDLE);
  assign load_out   = (state == DIV) && (state_next == DONE);

  // Delayed copies of vsync and de for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      de_q    <= de;
    end
  end

  // Pixel column and line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= de ? x_cnt + 11'd1 : 11'd0;
      if (vsync_rise)
        y_cnt <= '0;
      else if (de_q && !de)
        y_cnt <= y_cnt + 11'd1;
    end
  end

  // Foreground accumulators; the frame boundary clears them and drops the coincident pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (vsync_rise) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (de && mask) begin
      sum_x <= sum_x + {21'd0, x_cnt};
      sum_y <= sum_y + {21'd0, y_cnt};
      cnt   <= cnt + 22'd1;
    end
  end

  // One restoring-division step for each axis: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial_x = {rx, qx[31]};
    trial_y = {ry, qy[31]};
    diff_x  = trial_x - {1'b0, divisor};
    diff_y  = trial_y - {1'b0, divisor};
    ge_x    = (trial_x >= {1'b0, divisor});
    ge_y    = (trial_y >= {1'b0, divisor});
    rx_next = ge_x ? diff_x[21:0] : trial_x[21:0];
    ry_next = ge_y ? diff_y[21:0] : trial_y[21:0];
    qx_next = {qx[30:0], ge_x};
    qy_next = {qy[30:0], ge_y};
  end

  // Divider registers: snapshot at the frame boundary, iterate while in DIV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qx      <= '0;
      qy      <= '0;
      rx      <= '0;
      ry      <= '0;
      divisor <= '0;
      iter    <= '0;
    end else if (vsync_rise) begin
      qx      <= sum_x;
      qy      <= sum_y;
      rx      <= '0;
      ry      <= '0;
      divisor <= cnt;
      iter    <= '0;
    end else if (state == DIV) begin
      qx   <= qx_next;
      qy   <= qy_next;
      rx   <= rx_next;
      ry   <= ry_next;
      iter <= iter + 5'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next state; a frame boundary overrides whatever division is in flight
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      DIV:     if (iter == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (vsync_rise)
      state_next = (cnt != '0) ? DIV : IDLE;
  end

  // Result registers, loaded with the final quotient bit as the FSM enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_center       <= '0;
      y_center       <= '0;
      centroid_valid <= 1'b0;
    end else begin
      centroid_valid <= load_out;
      if (load_out) begin
        x_center <= qx_next[10:0];
        y_center <= qy_next[10:0];
      end
    end
  end

endmodule

// File: tb/tb_centroid_calc.sv
// tb/tb_centroid_calc.sv - directed self-checking bench for centroid_calc
module tb_centroid_calc;

  logic        clk = 1'b0;
  logic        rst_n, de, hsync, vsync, mask;
  logic [10:0] x_center, y_center;
  logic        centroid_valid, busy;

  int checks = 0;
  int failures = 0;

  centroid_calc #(.IMG_W(64), .IMG_H(64)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x_center(x_center), .y_center(y_center), .centroid_valid(centroid_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pix(input int mode, input int x, input int y);
    case (mode)
      0: return (x == 28 && y == 37);
      1: return 1'b1;
      2: return (x == 10 && y == 10) || (x == 13 && y == 20);
      3: return (x == 5 && y == 5);
      default: return 1'b0;
    endcase
  endfunction

  task automatic frame(input int mode);
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        step();
        de = 1'b1;
        hsync = 1'b0;
        mask = pix(mode, x, y);
      end
      for (int b = 0; b < 4; b++) begin
        step();
        de = 1'b0;
        mask = 1'b0;
        hsync = (b == 1);
      end
    end
  endtask

  // Watch n cycles; sample number k lands in cycle T+k of the last vsync rise
  task automatic observe(input int n, output int first, output int pulses, output int busy_seen);
    first = -1;
    pulses = 0;
    busy_seen = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 2) vsync = 1'b0;
      if (centroid_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (busy) busy_seen = 1;
    end
  endtask

  task automatic boundary(input bit exp_v, input int ex, input int ey, input string tag);
    int first, pulses, busy_seen;
    step();
    vsync = 1'b1;
    de = 1'b0;
    mask = 1'b0;
    observe(40, first, pulses, busy_seen);
    if (exp_v) begin
      chk({tag, "_valid_cycle"}, first, 33);
      chk({tag, "_pulses"}, pulses, 1);
    end else begin
      chk({tag, "_pulses"}, pulses, 0);
      chk({tag, "_busy"}, busy_seen, 0);
    end
    chk({tag, "_x"}, int'(x_center), ex);
    chk({tag, "_y"}, int'(y_center), ey);
  endtask

  initial begin
    int first, pulses, busy_seen, pre_pulses;
    rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = 1'b0;
    repeat (3) step();
    chk("reset_x", int'(x_center), 0);
    chk("reset_y", int'(y_center), 0);
    chk("reset_valid", int'(centroid_valid), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();

    boundary(1'b0, 0, 0, "first_empty");
    frame(0);
    boundary(1'b1, 28, 37, "single_px");
    frame(1);
    boundary(1'b1, 31, 31, "full_mask");
    frame(2);
    boundary(1'b1, 11, 15, "two_px");
    frame(3);
    boundary(1'b1, 5, 5, "px_5_5");
    frame(4);
    boundary(1'b0, 5, 5, "empty_keep");

    frame(0);
    step();
    vsync = 1'b1;
    observe(9, first, pulses, busy_seen);
    chk("mid_busy_before_reset", busy_seen, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_x", int'(x_center), 0);
    chk("mid_reset_y", int'(y_center), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_valid", int'(centroid_valid), 0);
    step();
    rst_n = 1'b1;
    observe(40, first, pulses, busy_seen);
    chk("post_reset_pulses", pulses, 0);
    frame(3);
    boundary(1'b1, 5, 5, "after_reset");

    frame(2);
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0; de = 1'b1; mask = 1'b0;
    step();
    step();
    step();
    mask = 1'b1;
    pre_pulses = int'(centroid_valid);
    step();
    pre_pulses += int'(centroid_valid);
    vsync = 1'b1; de = 1'b0; mask = 1'b0;
    observe(40, first, pulses, busy_seen);
    chk("restart_pre_pulses", pre_pulses, 0);
    chk("restart_valid_cycle", first, 33);
    chk("restart_pulses", pulses, 1);
    chk("restart_x", int'(x_center), 3);
    chk("restart_y", int'(y_center), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/centroid_calc.md
CENTROID_CALC -- requirements
Module: centroid_calc

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning active pixels per line (2..2047).
REQ-002 SHALL have parameter IMG_H, default 64, meaning active lines per frame (2..2047).
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port de  input  1  data enable, high during active pixels.
REQ-006 SHALL have port hsync  input  1  horizontal sync, accepted but not used for counting.
REQ-007 SHALL have port vsync  input  1  vertical sync, active-high; its rising edge is the frame boundary.
REQ-008 SHALL have port mask  input  1  foreground flag of the current pixel, valid when de=1.
REQ-009 SHALL have port x_center  output  11  centroid column of the last non-empty frame, registered.
REQ-010 SHALL have port y_center  output  11  centroid row of the last non-empty frame, registered.
REQ-011 SHALL have port centroid_valid  output  1  one-cycle pulse when x_center/y_center update.
REQ-012 SHALL have port busy  output  1  high while the divider runs.

Function
REQ-013 SHALL keep x_cnt (11 bit): cleared whenever de=0, and incremented by 1 after every cycle with de=1.
REQ-014 SHALL keep y_cnt (11 bit): incremented on every de falling edge, and cleared on every vsync rising edge.
REQ-015 SHALL accumulate on every cycle with de=1 and mask=1: sum_x += x_cnt, sum_y += y_cnt, cnt += 1.
REQ-016 SHALL use 32-bit sum_x and sum_y and a 22-bit cnt, all unsigned; overflow is impossible for the parameter range and is not checked.
REQ-017 SHALL detect the vsync rising edge (vsync=1 and registered vsync=0) in cycle T.
REQ-018 SHALL, in cycle T, snapshot sum_x, sum_y and cnt into the divider operands and clear the accumulators, whatever the FSM state.
REQ-019 SHALL implement the FSM states IDLE, DIV and DONE, with IDLE as the reset state.
REQ-020 SHALL move IDLE->DIV at a vsync rising edge when the snapshot cnt is nonzero.
REQ-021 SHALL stay in IDLE when the snapshot cnt is 0, leave the outputs unchanged, and not pulse centroid_valid.
REQ-022 SHALL, in DIV, run two parallel restoring dividers, sum_x/cnt and sum_y/cnt, at one quotient bit per cycle for 32 cycles (T+1..T+32).
REQ-023 SHALL move DIV->DONE after the 32nd iteration.
REQ-024 SHALL, in DONE (cycle T+33), load the 11 LSBs of each quotient into x_center/y_center, assert centroid_valid for that cycle only, and return to IDLE.
REQ-025 SHALL truncate the quotients (floor) and SHALL NOT round them.
REQ-026 SHALL assert busy in DIV and DONE, and deassert it in IDLE.
REQ-027 SHALL, on a vsync rising edge while in DIV or DONE, still snapshot and clear per REQ-018, discard the division in progress, and restart in DIV (or go to IDLE if cnt=0), with no valid pulse for the discarded frame.
REQ-028 SHALL be insensitive to hsync, and SHALL produce no output change from de or mask activity during DIV.
REQ-029 SHALL drop any pixel with de=1 in the same cycle as the vsync rising edge from the new frame; the snapshot has priority.

Reset
REQ-030 SHALL, while rst_n=0, force x_center=0, y_center=0, centroid_valid=0, busy=0, FSM=IDLE, all counters and accumulators to 0, and registered vsync to 0.
REQ-031 SHALL, on reset mid-division, abandon the result and produce no valid pulse after reset release.
REQ-032 SHALL treat the first vsync rising edge after reset as a normal boundary, so a partial first frame yields a centroid of whatever was accumulated.

Verification
REQ-033 SHALL verify a 64x64 frame with a single mask pixel at (28,37), then vsync rise -> x_center=28, y_center=37, and centroid_valid high exactly at T+33.
REQ-034 SHALL verify a 64x64 frame with mask=1 everywhere -> x_center=31, y_center=31 (floor of 31.5).
REQ-035 SHALL verify pixels at (10,10) and (13,20) -> x_center=11 (floor of 11.5) and y_center=15.
REQ-036 SHALL verify a frame after a (5,5) result that has no mask pixels -> outputs stay 5/5, no centroid_valid, busy stays 0.
REQ-037 SHALL verify rst_n pulsed low at T+10 of a division -> outputs 0, busy 0, and no centroid_valid until the next non-empty frame completes.
REQ-038 SHALL verify a second vsync rise injected at T+5 -> the first result is discarded, the single valid pulse occurs 33 cycles after the second edge, and its value matches the second frame's data.
